load_store_unit: RTL and testbench

Parametrised memory-access engine for the multicycle RV core: it takes one load/store request per transaction from the control/data path, handles byte-lane alignment, masking and sign extension, and drives a valid/ready memory port that tolerates variable latency. It generalises XLEN to 32 or 64, adds fault reporting for misaligned accesses, bus errors and a response timeout, and replaces the fixed single-cycle RAM access.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_byte_lane.sv | 47 ++++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMemReq,
        StMemWait,
        StResp
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_BYTE   = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF   = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD   = 2'b10;
    localparam logic [1:0] LSU_SIZE_DOUBLE = 2'b11;

    localparam logic [1:0] LSU_FAULT_NONE       = 2'd0;
    localparam logic [1:0] LSU_FAULT_MISALIGNED = 2'd1;
    localparam logic [1:0] LSU_FAULT_BUS        = 2'd2;
    localparam logic [1:0] LSU_FAULT_TIMEOUT    = 2'd3;

    // Access is illegal when the address is not size-aligned, or is a
    // double access on a 32-bit datapath.
    function automatic logic lsu_misaligned(input logic [2:0] addr_lsb,
                                            input logic [1:0] size,
                                            input logic       xlen64);
        logic bad;
        case (size)
            LSU_SIZE_BYTE: bad = 1'b0;
            LSU_SIZE_HALF: bad = addr_lsb[0];
            LSU_SIZE_WORD: bad = |addr_lsb[1:0];
            default:       bad = !xlen64 || (|addr_lsb);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: load extract/extend, store shift/mask.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    input  logic                         is_write,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [XLEN-1:0]              store_data,
    input  logic [XLEN-1:0]              mem_rdata,
    output logic [XLEN-1:0]              load_data,
    output logic [XLEN-1:0]              write_data,
    output logic [XLEN/8-1:0]            write_mask
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] msb;
    logic            sign;
    logic [6:0]      nbits;
    logic [3:0]      nbytes;
    logic [NB-1:0]   keep_b;

    // Load path: right-align the addressed lanes, then truncate and extend.
    // A full-width access shifts the one out entirely, so keep becomes all ones.
    always_comb begin
        nbits     = 7'd8 << size;
        shifted   = mem_rdata >> {offset, 3'b000};
        keep      = (XLEN'(1) << nbits) - XLEN'(1);
        msb       = keep & ~(keep >> 1);
        sign      = (|(shifted & msb)) & ~is_unsigned;
        load_data = (shifted & keep) | (sign ? ~keep : '0);
    end

    // Store path: move data into its lanes and build byte enables.
    always_comb begin
        nbytes     = 4'd1 << size;
        keep_b     = (NB'(1) << nbytes) - NB'(1);
        write_data = store_data << {offset, 3'b000};
        write_mask = is_write ? (keep_b << offset) : '0;
    end

endmodule

// File: rtl/load_store_unit.sv
// Serial load/store engine: one request at a time onto a valid/ready memory port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [XLEN-1:0]      req_address,
    input  logic [XLEN-1:0]      req_store_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_load_data,
    output logic                 resp_fault,
    output logic [1:0]           resp_fault_cause,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_write,
    output logic [XLEN-1:0]      mem_address,
    output logic [XLEN-1:0]      mem_write_data,
    output logic [XLEN/8-1:0]    mem_write_mask,
    input  logic                 mem_resp_valid,
    input  logic [XLEN-1:0]      mem_resp_data,
    input  logic                 mem_resp_error
);

    localparam int unsigned     NB         = XLEN / 8;
    localparam int unsigned     OFF_W      = $clog2(NB);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(NB - 1);
    localparam logic [31:0]     TMO        = 32'(TIMEOUT_CYCLES);

    lsu_state_e      state_q, state_d;
    logic            write_q, write_d;
    logic            unsigned_q, unsigned_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic            stale_q, stale_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] ldata_q, ldata_d;

    logic [XLEN-1:0] lane_load;
    logic            req_misaligned;

    assign req_misaligned = lsu_misaligned(3'(req_address[OFF_W-1:0]), req_size, XLEN == 64);

    lsu_byte_lane #(
        .XLEN(XLEN)
    ) u_byte_lane (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .is_write    (write_q),
        .offset      (addr_q[OFF_W-1:0]),
        .store_data  (sdata_q),
        .mem_rdata   (mem_resp_data),
        .load_data   (lane_load),
        .write_data  (mem_write_data),
        .write_mask  (mem_write_mask)
    );

    // Outputs decode from registered state only.
    assign req_ready        = (state_q == StIdle);
    assign resp_valid       = (state_q == StResp);
    assign mem_req_valid    = (state_q == StMemReq) && !stale_q;
    assign mem_write        = write_q;
    assign mem_address      = addr_q & ALIGN_MASK;
    assign resp_load_data   = ldata_q;
    assign resp_fault       = fault_q;
    assign resp_fault_cause = cause_q;

    // Next-state: request latch, memory handshake, timeout and stale tracking.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        stale_d    = stale_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        ldata_d    = ldata_q;

        // A timed-out transaction's late response is swallowed here.
        if (stale_q && mem_resp_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    size_d     = req_size;
                    addr_d     = req_address;
                    sdata_d    = req_store_data;
                    if (req_misaligned) begin
                        state_d = StResp;
                        fault_d = 1'b1;
                        cause_d = LSU_FAULT_MISALIGNED;
                        ldata_d = '0;
                    end else begin
                        state_d = StMemReq;
                    end
                end
            end
            StMemReq: begin
                if (mem_req_valid && mem_req_ready) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                // A response on the timeout edge still counts as a completion.
                if (mem_resp_valid) begin
                    state_d = StResp;
                    fault_d = mem_resp_error;
                    cause_d = mem_resp_error ? LSU_FAULT_BUS : LSU_FAULT_NONE;
                    ldata_d = (mem_resp_error || write_q) ? '0 : lane_load;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if (TIMEOUT_CYCLES != 0 && wait_cnt_d == TMO) begin
                        state_d = StResp;
                        fault_d = 1'b1;
                        cause_d = LSU_FAULT_TIMEOUT;
                        ldata_d = '0;
                        stale_d = 1'b1;
                    end
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= LSU_SIZE_BYTE;
            addr_q     <= '0;
            sdata_q    <= '0;
            stale_q    <= 1'b0;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
            cause_q    <= LSU_FAULT_NONE;
            ldata_q    <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            stale_q    <= stale_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
            ldata_q    <= ldata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit unit with a 4-cycle timeout and a 64-bit unit without.
module tb_load_store_unit;

    localparam int T0 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Index 0: 32-bit unit, index 1: 64-bit unit.
    logic        req_valid [2];
    logic        req_write [2];
    logic        req_unsigned [2];
    logic [1:0]  req_size [2];
    logic [63:0] req_address [2];
    logic [63:0] req_store_data [2];
    logic        resp_ready [2];
    logic        mem_req_ready [2];
    logic        mem_resp_valid [2];
    logic        mem_resp_error [2];
    logic [63:0] mem_resp_data [2];

    logic        o_req_ready [2];
    logic        o_resp_valid [2];
    logic        o_fault [2];
    logic        o_mem_req_valid [2];
    logic        o_mem_write [2];
    logic [1:0]  o_cause [2];
    logic [63:0] o_load [2];
    logic [63:0] o_maddr [2];
    logic [63:0] o_wdata [2];
    logic [7:0]  o_mask [2];

    logic a_rdy, a_rv, a_flt, a_mrv, a_mw;
    logic [1:0]  a_cause;
    logic [31:0] a_ld, a_ma, a_wd;
    logic [3:0]  a_mk;
    logic b_rdy, b_rv, b_flt, b_mrv, b_mw;
    logic [1:0]  b_cause;
    logic [63:0] b_ld, b_ma, b_wd;
    logic [7:0]  b_mk;

    always_comb begin
        o_req_ready[0] = a_rdy;      o_req_ready[1] = b_rdy;
        o_resp_valid[0] = a_rv;      o_resp_valid[1] = b_rv;
        o_fault[0] = a_flt;          o_fault[1] = b_flt;
        o_mem_req_valid[0] = a_mrv;  o_mem_req_valid[1] = b_mrv;
        o_mem_write[0] = a_mw;       o_mem_write[1] = b_mw;
        o_cause[0] = a_cause;        o_cause[1] = b_cause;
        o_load[0] = {32'h0, a_ld};   o_load[1] = b_ld;
        o_maddr[0] = {32'h0, a_ma};  o_maddr[1] = b_ma;
        o_wdata[0] = {32'h0, a_wd};  o_wdata[1] = b_wd;
        o_mask[0] = {4'h0, a_mk};    o_mask[1] = b_mk;
    end

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(T0)) u_lsu32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(a_rdy), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_address(req_address[0][31:0]), .req_store_data(req_store_data[0][31:0]),
        .resp_valid(a_rv), .resp_ready(resp_ready[0]), .resp_load_data(a_ld),
        .resp_fault(a_flt), .resp_fault_cause(a_cause),
        .mem_req_valid(a_mrv), .mem_req_ready(mem_req_ready[0]), .mem_write(a_mw),
        .mem_address(a_ma), .mem_write_data(a_wd), .mem_write_mask(a_mk),
        .mem_resp_valid(mem_resp_valid[0]), .mem_resp_data(mem_resp_data[0][31:0]),
        .mem_resp_error(mem_resp_error[0])
    );

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(0)) u_lsu64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(b_rdy), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_address(req_address[1]), .req_store_data(req_store_data[1]),
        .resp_valid(b_rv), .resp_ready(resp_ready[1]), .resp_load_data(b_ld),
        .resp_fault(b_flt), .resp_fault_cause(b_cause),
        .mem_req_valid(b_mrv), .mem_req_ready(mem_req_ready[1]), .mem_write(b_mw),
        .mem_address(b_ma), .mem_write_data(b_wd), .mem_write_mask(b_mk),
        .mem_resp_valid(mem_resp_valid[1]), .mem_resp_data(mem_resp_data[1]),
        .mem_resp_error(mem_resp_error[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what an access should look like on the bus and in the response.
    function automatic void model(input int xlen, input bit wr, input logic [1:0] sz,
                                  input bit uns, input logic [63:0] addr, sdata, rdata,
                                  output bit mis, output logic [63:0] ma, wd, ld,
                                  output logic [7:0] mk);
        int nb = 1 << sz;
        int lanes = xlen / 8;
        logic [63:0] xm = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        int off = int'((addr & xm) % 64'(lanes));
        logic [63:0] r;
        mis = ((addr % 64'(nb)) != 64'd0) || (nb > lanes);
        ma  = (addr & xm) - 64'(off);
        wd  = ((sdata & xm) << (8 * off)) & xm;
        mk  = wr ? 8'(((1 << nb) - 1) << off) : 8'h00;
        r   = (rdata & xm) >> (8 * off);
        case (nb)
            1:       ld = uns ? 64'(r[7:0])  : 64'($signed(r[7:0]));
            2:       ld = uns ? 64'(r[15:0]) : 64'($signed(r[15:0]));
            4:       ld = uns ? 64'(r[31:0]) : 64'($signed(r[31:0]));
            default: ld = r;
        endcase
        ld = ld & xm;
    endfunction

    // One full transaction with a scripted memory; latency reported as cycle number after accept.
    task automatic run_txn(input int u, input bit wr, input logic [1:0] sz, input bit uns,
                           input logic [63:0] addr, sdata, rdata, input bit err,
                           input int lat, input bit silent, input int stale_at,
                           input int rdy, input int hold,
                           output logic [63:0] got_ld, output int got_lat,
                           output logic [1:0] got_cause, output logic [63:0] got_ma,
                           output logic [63:0] got_wd, output logic [7:0] got_mk);
        int xlen = (u == 0) ? 32 : 64;
        int tmo = (u == 0) ? T0 : 0;
        bit mis, seen, done;
        logic [63:0] e_ma, e_wd, e_ld;
        logic [7:0] e_mk;
        logic [1:0] e_cause;
        int e_lat, hs, vcnt, k;
        model(xlen, wr, sz, uns, addr, sdata, rdata, mis, e_ma, e_wd, e_ld, e_mk);
        e_cause = mis ? 2'd1 : err ? 2'd2 : silent ? 2'd3 : 2'd0;
        if (e_cause != 2'd0 || wr) e_ld = 64'd0;
        seen = 0; done = 0; hs = -1; vcnt = 0; k = 0;
        got_ld = '0; got_lat = 0; got_cause = '0; got_ma = '0; got_wd = '0; got_mk = '0;

        chk("req_ready_idle", 64'(o_req_ready[u]), 64'd1);
        req_valid[u] = 1'b1; req_write[u] = wr; req_size[u] = sz; req_unsigned[u] = uns;
        req_address[u] = addr; req_store_data[u] = sdata;
        step();
        req_valid[u] = 1'b0;
        req_address[u] = {$urandom(), $urandom()};
        req_store_data[u] = {$urandom(), $urandom()};
        req_size[u] = 2'($urandom_range(0, 3));

        while (k < 80 && !done) begin
            if (o_resp_valid[u]) begin
                done = 1;
            end else begin
                if (stale_at >= 0 && k <= stale_at) begin
                    chk("stale_hold", 64'(o_mem_req_valid[u]), 64'd0);
                    if (k == stale_at) begin
                        mem_resp_valid[u] = 1'b1;
                        mem_resp_data[u] = {$urandom(), $urandom()};
                    end
                end else if (hs < 0 && o_mem_req_valid[u]) begin
                    chk("mem_write", 64'(o_mem_write[u]), 64'(wr));
                    chk("mem_address", o_maddr[u], e_ma);
                    chk("mem_mask", 64'(o_mask[u]), 64'(e_mk));
                    if (wr) chk("mem_wdata", o_wdata[u], e_wd);
                    got_ma = o_maddr[u]; got_wd = o_wdata[u]; got_mk = o_mask[u];
                    seen = 1;
                    if (vcnt == rdy) begin
                        mem_req_ready[u] = 1'b1;
                        hs = k;
                    end
                    vcnt++;
                end else if (hs >= 0 && !silent && k == hs + 1 + lat) begin
                    mem_resp_valid[u] = 1'b1;
                    mem_resp_data[u] = rdata;
                    mem_resp_error[u] = err;
                end
                step();
                mem_req_ready[u] = 1'b0;
                mem_resp_valid[u] = 1'b0;
                mem_resp_error[u] = 1'b0;
                mem_resp_data[u] = {$urandom(), $urandom()};
                k++;
            end
        end

        chk("resp_seen", 64'(done), 64'd1);
        chk("mem_req_issued", 64'(seen), 64'(!mis));
        if (done) begin
            e_lat = mis ? 1 : silent ? hs + tmo + 2 : hs + lat + 3;
            got_lat = k + 1;
            got_ld = o_load[u];
            got_cause = o_cause[u];
            chk("latency", 64'(got_lat), 64'(e_lat));
            chk("resp_fault", 64'(o_fault[u]), 64'(e_cause != 2'd0));
            chk("resp_cause", 64'(o_cause[u]), 64'(e_cause));
            chk("resp_data", o_load[u], e_ld);
            for (int i = 0; i < hold; i++) begin
                step();
                chk("hold_valid", 64'(o_resp_valid[u]), 64'd1);
                chk("hold_data", o_load[u], e_ld);
                chk("hold_cause", 64'(o_cause[u]), 64'(e_cause));
            end
        end
        resp_ready[u] = 1'b1;
        step();
        resp_ready[u] = 1'b0;
        chk("back_to_idle", 64'(o_req_ready[u]), 64'd1);
        chk("resp_dropped", 64'(o_resp_valid[u]), 64'd0);
    endtask

    logic [63:0] gld, gma, gwd;
    logic [1:0]  gc;
    logic [7:0]  gmk;
    int          glat;

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 0; req_write[u] = 0; req_unsigned[u] = 0; req_size[u] = 0;
            req_address[u] = 0; req_store_data[u] = 0; resp_ready[u] = 0;
            mem_req_ready[u] = 0; mem_resp_valid[u] = 0; mem_resp_error[u] = 0;
            mem_resp_data[u] = 0;
        end
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            chk("rst_req_ready", 64'(o_req_ready[u]), 64'd1);
            chk("rst_resp_valid", 64'(o_resp_valid[u]), 64'd0);
            chk("rst_mem_req_valid", 64'(o_mem_req_valid[u]), 64'd0);
            chk("rst_fault", 64'(o_fault[u]), 64'd0);
            chk("rst_cause", 64'(o_cause[u]), 64'd0);
            chk("rst_load", o_load[u], 64'd0);
        end
        reset = 1'b0;
        step();

        // LB 0x103 on 32-bit, single-cycle memory.
        run_txn(0, 0, 2'b00, 0, 64'h103, 64'h0, 64'h80AB_CDEF, 0, 0, 0, -1, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("lb_data", gld, 64'hFFFF_FF80);
        chk("lb_latency", 64'(glat), 64'd3);

        // SH 0x202 on 32-bit.
        run_txn(0, 1, 2'b01, 0, 64'h202, 64'h1234, 64'h0, 0, 0, 0, -1, 1, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("sh_addr", gma, 64'h200);
        chk("sh_wdata_hi", 64'(gwd[31:16]), 64'h1234);
        chk("sh_mask", 64'(gmk), 64'hC);

        // LWU 0x4 on 64-bit.
        run_txn(1, 0, 2'b10, 1, 64'h4, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 1, 0, -1, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("lwu_data", gld, 64'h0000_0000_DEAD_BEEF);

        // LW 0x102: misaligned, no memory access.
        run_txn(0, 0, 2'b10, 0, 64'h102, 64'h0, 64'h0, 0, 0, 0, -1, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("mis_cause", 64'(gc), 64'd1);
        chk("mis_latency", 64'(glat), 64'd1);

        // Silent memory times out; the late response is dropped before the next load.
        run_txn(0, 0, 2'b10, 0, 64'h40, 64'h0, 64'h0, 0, 0, 1, -1, 0, 1,
                gld, glat, gc, gma, gwd, gmk);
        chk("tmo_cause", 64'(gc), 64'd3);
        run_txn(0, 0, 2'b01, 0, 64'h46, 64'h0, 64'h9876_5432, 0, 0, 0, 2, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("after_stale_data", gld, 64'h0000_0000_FFFF_9876);

        // Response on the timeout edge completes normally and leaves no stale state.
        run_txn(0, 0, 2'b10, 1, 64'h80, 64'h0, 64'h1357_9BDF, 0, T0 - 1, 0, -1, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("race_cause", 64'(gc), 64'd0);
        run_txn(0, 0, 2'b00, 1, 64'h81, 64'h0, 64'h0000_AA00, 0, 0, 0, -1, 0, 0,
                gld, glat, gc, gma, gwd, gmk);
        chk("race_next_latency", 64'(glat), 64'd3);

        // Bus error with resp_ready held low for five cycles.
        run_txn(1, 0, 2'b11, 0, 64'h1000, 64'h0, 64'h1111_2222_3333_4444, 1, 0, 0, -1, 0, 5,
                gld, glat, gc, gma, gwd, gmk);
        chk("bus_cause", 64'(gc), 64'd2);

        // Reset during MEM_WAIT returns to idle at once.
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b11; req_address[1] = 64'h2000;
        step();
        req_valid[1] = 1'b0;
        mem_req_ready[1] = 1'b1;
        step();
        mem_req_ready[1] = 1'b0;
        step();
        chk("pre_rst_busy", 64'(o_req_ready[1]), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ready", 64'(o_req_ready[1]), 64'd1);
        chk("async_rst_resp", 64'(o_resp_valid[1]), 64'd0);
        chk("async_rst_mreq", 64'(o_mem_req_valid[1]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 64'(o_req_ready[1]), 64'd1);

        // Randomised traffic on both widths.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 30; n++) begin
                logic [1:0]  sz;
                logic [63:0] addr;
                sz = 2'($urandom_range(0, 3));
                addr = (u == 0) ? {32'h0, $urandom()} : {$urandom(), $urandom()};
                if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << sz) - 1);
                run_txn(u, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                        {$urandom(), $urandom()}, {$urandom(), $urandom()},
                        $urandom_range(0, 7) == 0, $urandom_range(0, 2), 0, -1,
                        $urandom_range(0, 2), $urandom_range(0, 2),
                        gld, glat, gc, gma, gwd, gmk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
